// File: rtl/ram_bist_ctrl.sv
// Two-pass write/read-back self-test master for a small synchronous RAM (P(a)=a^seed, then ~P(a)).
// Latency: 4*RAM_DEPTH+2 busy cycles from accepted start, then a one-cycle done pulse; no backpressure, start ignored unless idle.
module ram_bist_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 8,
    parameter int ERR_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_seed,
    output logic                  o_write_en,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_read_en,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_WIDTH-1:0]  o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_CMP0,
        S_WR1,
        S_RD1,
        S_CMP1,
        S_FIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] sd,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] p;
        p = DATA_WIDTH'(addr) ^ sd;
        return inv ? ~p : p;
    endfunction

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0]   r_seed;
    logic                    r_rd_vld;
    logic [DATA_WIDTH-1:0]   r_rd_exp;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_err_seen;

    logic                    r_write_en;
    logic [ADDR_WIDTH-1:0]   r_write_addr;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic                    r_read_en;
    logic [ADDR_WIDTH-1:0]   r_read_addr;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [ERR_WIDTH-1:0]    r_err_cnt;
    logic [ADDR_WIDTH-1:0]   r_first_err_addr;

    logic                    w_mis;
    logic [ERR_WIDTH-1:0]    w_err_nxt;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_cnt_inc;
    logic                    w_inv;

    // The compare stage sees the word requested one cycle earlier, so the
    // expected value and its address travel alongside the read request.
    assign w_mis     = r_rd_vld && (i_read_data != r_rd_exp);
    assign w_err_nxt = (w_mis && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;
    assign w_last    = (r_cnt == LAST_ADDR);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_inv     = (r_state == S_WR1) || (r_state == S_RD1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_seed           <= '0;
            r_rd_vld         <= 1'b0;
            r_rd_exp         <= '0;
            r_rd_addr        <= '0;
            r_err_seen       <= 1'b0;
            r_write_en       <= 1'b0;
            r_write_addr     <= '0;
            r_write_data     <= '0;
            r_read_en        <= 1'b0;
            r_read_addr      <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_rd_vld  <= r_read_en;
            r_rd_exp  <= pattern(r_read_addr, r_seed, w_inv);
            r_rd_addr <= r_read_addr;
            r_err_cnt <= w_err_nxt;
            if (w_mis && !r_err_seen) begin
                r_first_err_addr <= r_rd_addr;
                r_err_seen       <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_seed           <= i_seed;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_err_seen       <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_cnt            <= '0;
                        r_write_en       <= 1'b1;
                        r_write_addr     <= '0;
                        r_write_data     <= pattern('0, i_seed, 1'b0);
                        r_state          <= S_WR0;
                    end
                end
                S_WR0, S_WR1: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_write_en   <= 1'b0;
                        r_write_addr <= '0;
                        r_write_data <= '0;
                        r_read_en    <= 1'b1;
                        r_read_addr  <= '0;
                        r_state      <= (r_state == S_WR0) ? S_RD0 : S_RD1;
                    end else begin
                        r_cnt        <= w_cnt_inc;
                        r_write_addr <= w_cnt_inc;
                        r_write_data <= pattern(w_cnt_inc, r_seed, w_inv);
                    end
                end
                S_RD0, S_RD1: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_read_en   <= 1'b0;
                        r_read_addr <= '0;
                        r_state     <= (r_state == S_RD0) ? S_CMP0 : S_CMP1;
                    end else begin
                        r_cnt       <= w_cnt_inc;
                        r_read_addr <= w_cnt_inc;
                    end
                end
                S_CMP0: begin
                    r_cnt        <= '0;
                    r_write_en   <= 1'b1;
                    r_write_addr <= '0;
                    r_write_data <= pattern('0, r_seed, 1'b1);
                    r_state      <= S_WR1;
                end
                S_CMP1: begin
                    // The final read word is still being scored this cycle.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_nxt == '0);
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_write_en       = r_write_en;
    assign o_write_addr     = r_write_addr;
    assign o_write_data     = r_write_data;
    assign o_read_en        = r_read_en;
    assign o_read_addr      = r_read_addr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err_addr;

endmodule
